// File: rtl/sound_synth_nch.sv
// Multi-channel square/noise tone generator with per-channel ASR envelopes, a summing mixer
// and a first-order sigma-delta speaker output. Define SNDGEN_LFO_EN for the shared period LFO.
module sound_synth_nch #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned FREQ_W    = 12,
    parameter int unsigned PRESCALE  = 16,
    parameter logic [15:0] LFSR_TAPS = 16'hB400,
    parameter int unsigned ENV_W     = 8,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned SAMPLE_W = 4 + $clog2(NUM_CH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en_i,
    input  logic [CH_W-1:0]     wr_ch_i,
    input  logic [1:0]          wr_reg_i,
    input  logic [15:0]         wr_data_i,
    input  logic [9:0]          lfo_freq_i,
    output logic [SAMPLE_W-1:0] sample_out_o,
    output logic                spkr_o,
    output logic [NUM_CH-1:0]   busy_o
);

    typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} env_state_e;

    localparam int unsigned PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0]     presc_q, presc_d;
    logic                tick;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d, mix_sum;
    logic [SAMPLE_W-1:0] acc_q, acc_d;
    logic [SAMPLE_W:0]   acc_sum;
    logic                spkr_q, spkr_d;

    logic [FREQ_W-1:0] period_q [NUM_CH];
    logic [FREQ_W-1:0] period_d [NUM_CH];
    logic [FREQ_W-1:0] count_q  [NUM_CH];
    logic [FREQ_W-1:0] count_d  [NUM_CH];
    logic [FREQ_W-1:0] reload   [NUM_CH];
    logic [3:0]        vol_q    [NUM_CH];
    logic [3:0]        vol_d    [NUM_CH];
    logic              gate_q   [NUM_CH];
    logic              gate_d   [NUM_CH];
    logic              noise_q  [NUM_CH];
    logic              noise_d  [NUM_CH];
    logic              wave_q   [NUM_CH];
    logic              wave_d   [NUM_CH];
    logic [ENV_W-1:0]  rate_q   [NUM_CH];
    logic [ENV_W-1:0]  rate_d   [NUM_CH];
    logic [ENV_W-1:0]  div_q    [NUM_CH];
    logic [ENV_W-1:0]  div_d    [NUM_CH];
    logic              step     [NUM_CH];
    logic [3:0]        level_q  [NUM_CH];
    logic [3:0]        level_d  [NUM_CH];
    env_state_e        state_q  [NUM_CH];
    env_state_e        state_d  [NUM_CH];
    logic [7:0]        prod     [NUM_CH];
    logic [3:0]        amp      [NUM_CH];

    // Bits of the write bus and LFO input that a given configuration does not decode.
    logic unused_bits;
    assign unused_bits = ^{lfo_freq_i, wr_data_i};

    always_comb begin
        tick    = (presc_q == '0);
        presc_d = presc_q + PS_W'(1);
        lfsr_d  = lfsr_q;
        if (tick) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

`ifdef SNDGEN_LFO_EN
    logic [17:0] lfo_q, lfo_d;
    logic [11:0] lfo_tri;
    logic [2:0]  lfo_shift_q [NUM_CH];
    logic [2:0]  lfo_shift_d [NUM_CH];
    logic        lfo_mod_q   [NUM_CH];
    logic        lfo_mod_d   [NUM_CH];

    always_comb begin
        lfo_d = lfo_q;
        if (tick) begin
            lfo_d = (lfo_q == '0) ? {lfo_freq_i, 8'h00} : lfo_q - 18'd1;
        end
        // Fold the ramp on its MSB so the offset rises and falls.
        lfo_tri = lfo_q[17] ? ~lfo_q[17:6] : lfo_q[17:6];
    end
`endif

    always_comb begin
        mix_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            period_d[c] = period_q[c];
            count_d[c]  = count_q[c];
            vol_d[c]    = vol_q[c];
            gate_d[c]   = gate_q[c];
            noise_d[c]  = noise_q[c];
            wave_d[c]   = wave_q[c];
            rate_d[c]   = rate_q[c];
            div_d[c]    = div_q[c];
            level_d[c]  = level_q[c];
            state_d[c]  = state_q[c];
            step[c]     = 1'b0;
            reload[c]   = period_q[c];
`ifdef SNDGEN_LFO_EN
            lfo_shift_d[c] = lfo_shift_q[c];
            lfo_mod_d[c]   = lfo_mod_q[c];
            if (lfo_mod_q[c]) begin
                reload[c] = period_q[c] + FREQ_W'(lfo_tri >> lfo_shift_q[c]);
            end
`endif
            if (tick) begin
                if (count_q[c] == '0) begin
                    count_d[c] = reload[c];
                    wave_d[c]  = noise_q[c] ? lfsr_q[0] : ~wave_q[c];
                end else begin
                    count_d[c] = count_q[c] - FREQ_W'(1);
                end
                if (period_q[c] == '0) begin
                    wave_d[c] = 1'b0;
                end
                if (div_q[c] == '0) begin
                    div_d[c] = rate_q[c];
                    step[c]  = 1'b1;
                end else begin
                    div_d[c] = div_q[c] - ENV_W'(1);
                end
            end

            case (state_q[c])
                StIdle: level_d[c] = 4'd0;
                StAttack: begin
                    if (level_q[c] == 4'd15) begin
                        state_d[c] = StSustain;
                    end else if (step[c]) begin
                        level_d[c] = level_q[c] + 4'd1;
                        if (level_q[c] == 4'd14) state_d[c] = StSustain;
                    end
                end
                StSustain: level_d[c] = 4'd15;
                StRelease: begin
                    if (level_q[c] == 4'd0) begin
                        state_d[c] = StIdle;
                    end else if (step[c]) begin
                        level_d[c] = level_q[c] - 4'd1;
                        if (level_q[c] == 4'd1) state_d[c] = StIdle;
                    end
                end
                default: state_d[c] = StIdle;
            endcase

            // Writes land after the tick update so a same-clk tick sees pre-write values.
            if (wr_en_i && (wr_ch_i == CH_W'(c))) begin
                case (wr_reg_i)
                    2'd0: period_d[c] = wr_data_i[FREQ_W-1:0];
                    2'd1: begin
                        vol_d[c]   = wr_data_i[3:0];
                        gate_d[c]  = wr_data_i[4];
                        noise_d[c] = wr_data_i[5];
`ifdef SNDGEN_LFO_EN
                        lfo_shift_d[c] = wr_data_i[8:6];
                        lfo_mod_d[c]   = wr_data_i[9];
`endif
                        if (wr_data_i[4] && !gate_q[c]) begin
                            state_d[c] = StAttack;
                        end else if (!wr_data_i[4] && gate_q[c] &&
                                     (state_d[c] inside {StAttack, StSustain})) begin
                            state_d[c] = StRelease;
                        end
                    end
                    2'd2: begin
                        rate_d[c] = wr_data_i[ENV_W-1:0];
                        div_d[c]  = wr_data_i[ENV_W-1:0];
                    end
                    default: ;
                endcase
            end

            prod[c] = 8'(level_d[c]) * 8'(vol_q[c]);
            amp[c]  = wave_d[c] ? prod[c][7:4] : 4'd0;
            mix_sum = mix_sum + SAMPLE_W'(amp[c]);
        end
    end

    always_comb begin
        sample_d = tick ? mix_sum : sample_q;
        acc_sum  = {1'b0, acc_q} + {1'b0, sample_q};
        acc_d    = acc_sum[SAMPLE_W-1:0];
        spkr_d   = acc_sum[SAMPLE_W];
        busy_o   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            busy_o[c] = (state_q[c] != StIdle);
        end
    end

    assign sample_out_o = sample_q;
    assign spkr_o       = spkr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            lfsr_q   <= 16'h0001;
            sample_q <= '0;
            acc_q    <= '0;
            spkr_q   <= 1'b0;
`ifdef SNDGEN_LFO_EN
            lfo_q    <= '0;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                period_q[c] <= '0;
                count_q[c]  <= '0;
                vol_q[c]    <= '0;
                gate_q[c]   <= 1'b0;
                noise_q[c]  <= 1'b0;
                wave_q[c]   <= 1'b0;
                rate_q[c]   <= '0;
                div_q[c]    <= '0;
                level_q[c]  <= '0;
                state_q[c]  <= StIdle;
`ifdef SNDGEN_LFO_EN
                lfo_shift_q[c] <= '0;
                lfo_mod_q[c]   <= 1'b0;
`endif
            end
        end else begin
            presc_q  <= presc_d;
            lfsr_q   <= lfsr_d;
            sample_q <= sample_d;
            acc_q    <= acc_d;
            spkr_q   <= spkr_d;
`ifdef SNDGEN_LFO_EN
            lfo_q    <= lfo_d;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                period_q[c] <= period_d[c];
                count_q[c]  <= count_d[c];
                vol_q[c]    <= vol_d[c];
                gate_q[c]   <= gate_d[c];
                noise_q[c]  <= noise_d[c];
                wave_q[c]   <= wave_d[c];
                rate_q[c]   <= rate_d[c];
                div_q[c]    <= div_d[c];
                level_q[c]  <= level_d[c];
                state_q[c]  <= state_d[c];
`ifdef SNDGEN_LFO_EN
                lfo_shift_q[c] <= lfo_shift_d[c];
                lfo_mod_q[c]   <= lfo_mod_d[c];
`endif
            end
        end
    end

endmodule

// File: tb/tb_sound_synth_nch.sv
// Directed self-checking bench for sound_synth_nch (3 channels, PRESCALE 16, LFO disabled).
module tb_sound_synth_nch;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [1:0] wr_reg;
    logic [15:0] wr_data;
    logic [9:0] lfo_freq;
    logic [5:0] sample_out;
    logic       spkr;
    logic [2:0] busy;

    int checks   = 0;
    int failures = 0;
    int ph       = 0;  // mirror of the prescaler value after the most recent clk
    int hi;

    always #5 clk = ~clk;

    sound_synth_nch dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (wr_en),
        .wr_ch_i      (wr_ch),
        .wr_reg_i     (wr_reg),
        .wr_data_i    (wr_data),
        .lfo_freq_i   (lfo_freq),
        .sample_out_o (sample_out),
        .spkr_o       (spkr),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            ph = (ph + 1) % 16;
        end
    endtask

    // Each iteration passes exactly one tick and stops at the negedge just after it.
    task automatic ticks(input int n);
        repeat (n) begin
            do adv(1); while (ph != 1);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] rg, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_reg  = rg;
        wr_data = d;
        adv(1);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        adv(n);
        reset = 1'b0;
        ph    = 0;
    endtask

    initial begin
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_reg   = '0;
        wr_data  = '0;
        lfo_freq = '0;

        // Reset state
        do_reset(3);
        chk("rst_sample", 32'(sample_out), 32'd0);
        chk("rst_spkr", 32'(spkr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0001);

        // Ch0 square: period 4, volume 15, rate 0
        adv(1);
        wr(2'd0, 2'd0, 16'd4);
        wr(2'd0, 2'd2, 16'd0);
        wr(2'd0, 2'd1, 16'h001F);
        chk("ch0_busy_rise", 32'(busy), 32'd1);
        ticks(3);
        chk("ch0_t3", 32'(sample_out), 32'd2);
        ticks(2);
        chk("ch0_t5", 32'(sample_out), 32'd4);
        ticks(1);
        chk("ch0_t6_low", 32'(sample_out), 32'd0);
        ticks(5);
        chk("ch0_t11", 32'(sample_out), 32'd10);
        ticks(4);
        chk("ch0_t15_full", 32'(sample_out), 32'd14);
        ticks(1);
        chk("ch0_t16_low", 32'(sample_out), 32'd0);
        ticks(5);
        chk("ch0_t21_high", 32'(sample_out), 32'd14);

        // Reset mid-note with a simultaneous gate write that must be dropped
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd1;
        wr_reg  = 2'd1;
        wr_data = 16'h001F;
        adv(1);
        reset   = 1'b0;
        wr_en   = 1'b0;
        ph      = 0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sample", 32'(sample_out), 32'd0);
        chk("midrst_spkr", 32'(spkr), 32'd0);

        // Ch1 envelope: long period keeps wave high, so sample = level - 1
        adv(1);
        wr(2'd1, 2'd0, 16'd4095);
        wr(2'd1, 2'd2, 16'd0);
        wr(2'd1, 2'd1, 16'h001F);
        ticks(8);
        chk("env_attack_l8", 32'(sample_out), 32'd7);
        wr(2'd1, 2'd1, 16'h000F);
        chk("env_rel_busy", 32'(busy), 32'd2);
        ticks(1);
        chk("env_rel_l7", 32'(sample_out), 32'd6);
        ticks(4);
        chk("env_rel_l3", 32'(sample_out), 32'd2);
        wr(2'd1, 2'd1, 16'h001F);
        ticks(1);
        chk("env_reattack_l4", 32'(sample_out), 32'd3);
        ticks(10);
        chk("env_attack_l14", 32'(sample_out), 32'd13);
        ticks(1);
        chk("env_sustain_l15", 32'(sample_out), 32'd14);
        ticks(1);
        chk("env_sustain_hold", 32'(sample_out), 32'd14);
        wr(2'd1, 2'd1, 16'h000F);
        ticks(14);
        chk("env_rel_l1_busy", 32'(busy), 32'd2);
        ticks(1);
        chk("env_idle_busy", 32'(busy), 32'd0);
        chk("env_idle_sample", 32'(sample_out), 32'd0);
        hi = 0;
        repeat (32) begin
            adv(1);
            if (spkr) hi++;
        end
        chk("spkr_quiet", 32'(hi), 32'd0);

        // All channels sustained at volume 15
        do_reset(1);
        adv(1);
        for (int c = 0; c < 3; c++) begin
            wr(2'(c), 2'd0, 16'd4095);
            wr(2'(c), 2'd2, 16'd0);
            wr(2'(c), 2'd1, 16'h001F);
        end
        ticks(15);
        chk("mix_full", 32'(sample_out), 32'd42);
        chk("mix_busy", 32'(busy), 32'd7);
        hi = 0;
        repeat (640) begin
            adv(1);
            if (spkr) hi++;
        end
        chk("spkr_duty", 32'(hi), 32'd420);

        // Out-of-range channel and reserved register writes
        wr(2'd3, 2'd1, 16'h000F);
        chk("ch3_busy", 32'(busy), 32'd7);
        wr(2'd0, 2'd3, 16'h0000);
        ticks(1);
        chk("ignored_writes", 32'(sample_out), 32'd42);

        // Period 0 silences ch2 while its envelope stays active
        wr(2'd2, 2'd0, 16'd0);
        ticks(1);
        chk("period0_sample", 32'(sample_out), 32'd28);
        chk("period0_busy", 32'(busy), 32'd7);

        // Rate 2 on ch0: release steps every third tick
        wr(2'd0, 2'd2, 16'd2);
        wr(2'd0, 2'd1, 16'h000F);
        ticks(2);
        chk("rate_hold", 32'(sample_out), 32'd28);
        ticks(1);
        chk("rate_step", 32'(sample_out), 32'd27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
